// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU and response signals between the arbiter and its environment.
// The slave modport is the arbiter side. The master modport is the requester, ALU and consumer side.
interface alu_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_setflags;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_setflags;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_v;
  logic        alu_z;
  logic        alu_c;
  logic        alu_s;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  flags_q;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_setflags,
    input  req1_valid, req1_op, req1_a, req1_b, req1_setflags,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_opcode,
    input  alu_result, alu_v, alu_z, alu_c, alu_s,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready,
    output flags_q, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_setflags,
    output req1_valid, req1_op, req1_a, req1_b, req1_setflags,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_opcode,
    output alu_result, alu_v, alu_z, alu_c, alu_s,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output rsp_ready,
    input  flags_q, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one 16-bit ALU between the execute datapath (port 0) and the
// address/branch unit (port 1). It registers the operands, captures the result, and keeps the architectural flags.
module alu_share_arbiter (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic [3:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_setflags;
  logic        r_id;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [15:0] r_rsp_result;
  logic [3:0]  r_rsp_flags;
  logic        r_rsp_err;
  logic [3:0]  r_flags;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_op_legal;

  // A tie goes to the port that did not win last time.
  assign w_grant0   = bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_grant1   = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_idle     = (r_state == IDLE) && !rst;
  assign w_op_legal = (r_op == 4'h0) || (r_op == 4'h1) || (r_op == 4'h8) || (r_op == 4'h9);

  assign bus.req0_ready = w_idle && w_grant0;
  assign bus.req1_ready = w_idle && w_grant1;
  assign bus.alu_in1    = r_a;
  assign bus.alu_in2    = r_b;
  assign bus.alu_opcode = r_op;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.flags_q    = r_flags;
  assign bus.busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_op         <= 4'h0;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_setflags   <= 1'b0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 16'h0000;
      r_rsp_flags  <= 4'h0;
      r_rsp_err    <= 1'b0;
      r_flags      <= 4'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_op         <= w_grant1 ? bus.req1_op : bus.req0_op;
            r_a          <= w_grant1 ? bus.req1_a : bus.req0_a;
            r_b          <= w_grant1 ? bus.req1_b : bus.req0_b;
            r_setflags   <= w_grant1 ? bus.req1_setflags : bus.req0_setflags;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported opcodes report a zero result whatever the ALU produced.
          r_rsp_result <= w_op_legal ? bus.alu_result : 16'h0000;
          r_rsp_flags  <= {bus.alu_s, bus.alu_z, bus.alu_c, bus.alu_v};
          r_rsp_err    <= !w_op_legal;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            if (r_setflags && !r_rsp_err) begin
              r_flags <= r_rsp_flags;
            end
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single 16-bit ALU (opcodes 0 add, 1 sub, 8 and, 9 or) between two requesters: port 0 is the execute datapath and port 1 is the address/branch unit. The block round-robin arbitrates valid/ready requests and registers the operands into the ALU. It captures the result and flags one cycle later, returns them through a response handshake, and maintains the architectural flag register. It sits between the decode/phase logic and the combinational ALU.

## Interface
- No parameters; data width fixed at 16, opcode width fixed at 4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N = 0, 1) request pending.
- reqN_ready  out  1  request accepted this cycle when valid && ready.
- reqN_op  in  4  ALU opcode.
- reqN_a, reqN_b  in  16  operands.
- reqN_setflags  in  1  commit flags to flags_q on completion.
- alu_in1, alu_in2  out  16  to ALU in1/in2.
- alu_opcode  out  4  to ALU opcode.
- alu_result  in  16  from ALU.
- alu_v, alu_z, alu_c, alu_s  in  1  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  16  captured result.
- rsp_flags  out  4  captured {s,z,c,v}.
- rsp_err  out  1  opcode not in {0,1,8,9}.
- flags_q  out  4  architectural {s,z,c,v}.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant to the single valid requester.
  - If both requesters are valid, grant to the one not equal to last_grant.
  - reqN_ready = 1 only for the granted N, combinationally from valid and last_grant; both readies are 0 outside IDLE.
  - On accept: latch op/a/b/setflags/id into operand registers, set last_grant = N, go to EXEC.
- alu_in1, alu_in2 and alu_opcode are driven directly from the operand registers at all times.
- EXEC (exactly one cycle):
  - Capture alu_result and {alu_s,alu_z,alu_c,alu_v} into rsp registers.
  - rsp_err = op not in {0,1,8,9}.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* are held stable until rsp_ready = 1.
  - On rsp_ready: if setflags && !rsp_err, flags_q takes rsp_flags. Go to IDLE.
- Unsupported opcodes still complete with result 0 and rsp_err = 1. flags_q is never updated for them.
- No new request is accepted in the cycle in which a response handshakes; the earliest next accept is the following cycle.

## Timing
- Reset values: state IDLE; last_grant = 1, so port 0 wins the first tie; operand registers = 0 (alu_in1 = alu_in2 = 0, alu_opcode = 0); rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0, rsp_err = 0; flags_q = 0; busy = 0; reqN_ready = 0 while rst.
- Latency: accept at cycle T, EXEC at T+1, rsp_valid first high at T+2. Minimum issue interval is 3 cycles.
- Backpressure: rsp_valid stays high indefinitely while rsp_ready = 0. No request is accepted during that time; the requester holds valid.
- rsp_ready is ignored when rsp_valid = 0.
- Reset mid-operation, in EXEC or RESP: the in-flight op is dropped, no response is produced, flags_q is cleared, and the grant pointer returns to its reset value.
- A requester that deasserts valid before ready is simply not granted; there is no error.
- Flags are bit-exact pass-through of the ALU outputs; the block performs no arithmetic.

## Test plan
- Single add: after reset, req0 op 0, a = 16'h0003, b = 16'h0004, setflags = 1 → req0_ready at T. rsp_valid at T+2 with rsp_id = 0, rsp_result = 16'h0007, rsp_err = 0. After handshake, flags_q = {s,z,c,v} from the ALU: s = 0, z = 0.
- Tie and round-robin: both valid continuously with rsp_ready = 1 → grants alternate 0, 1, 0, 1, one accept every 3 cycles. A sub with req1 a = 5, b = 5 returns rsp_result = 0 and z = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp fields are stable, req0_ready and req1_ready stay 0, busy = 1. Release → back to IDLE next cycle.
- Illegal opcode: req1 op 4'hF, a = 16'hFFFF, setflags = 1 with flags_q previously 4'b0100 → rsp_result = 0, rsp_err = 1, flags_q remains 4'b0100.
- setflags = 0: req0 op 8, a = 16'hF0F0, b = 16'h0FF0 → rsp_result = 16'h00F0, flags_q unchanged.
- Reset mid-EXEC: assert rst in the EXEC cycle → next cycle all outputs are at reset values and no rsp_valid ever appears for the dropped op. After release, the first tie grants port 0.
